// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / condition-code unit.
//   op_e      : 3-bit operation encodings presented on in_op
//   cond_e    : y86-style condition selects presented on cond_fn
//   state_e   : control FSM states
//   CC_*_RST  : condition-code register values after reset
//   cond_eval : evaluates a condition select against a CC triple
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_MUL  = 3'b100,
        OP_RSV5 = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'd0,
        COND_LE     = 4'd1,
        COND_L      = 4'd2,
        COND_E      = 4'd3,
        COND_NE     = 4'd4,
        COND_GE     = 4'd5,
        COND_G      = 4'd6
    } cond_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    localparam logic CC_ZF_RST = 1'b1;
    localparam logic CC_SF_RST = 1'b0;
    localparam logic CC_OF_RST = 1'b0;

    // Unlisted selects (7..15) never fire.
    function automatic logic cond_eval(input logic [3:0] fn, input logic zf,
                                       input logic sf, input logic of);
        logic lt;
        logic res;
        lt  = sf ^ of;
        res = 1'b0;
        case (fn)
            COND_ALWAYS: res = 1'b1;
            COND_LE:     res = lt | zf;
            COND_L:      res = lt;
            COND_E:      res = zf;
            COND_NE:     res = !zf;
            COND_GE:     res = !lt;
            COND_G:      res = !lt && !zf;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_cc_unit_if.sv
// Request/response bundle for alu_cc_unit.
//   in_*  : operation request (valid/ready handshake)
//   out_* : result response (valid/ready handshake)
//   master: the requester/consumer side, slave: the ALU side
interface alu_cc_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_set_cc, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_set_cc, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Radix-2 iterative signed multiplier.
//   start   : load operands (one-cycle pulse)
//   a, b    : signed operands, sampled on start
//   done    : high in the cycle whose edge completes the last iteration;
//             product/ovf are valid while done is high
//   product : low WIDTH bits of the signed product
//   ovf     : full 2*WIDTH product does not fit in WIDTH signed bits
// Magnitudes are multiplied with shift-add and the sign applied at the end.
// done/product come from the combinational last step so the result can be
// captured on the WIDTH-th edge after start.
module alu_mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    logic                 busy_reg;
    logic [CW-1:0]        cnt_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic                 neg_reg;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   full;

    // -MIN wraps to MIN, which is the right magnitude when read unsigned.
    assign abs_a    = a[WIDTH-1] ? -a : a;
    assign abs_b    = b[WIDTH-1] ? -b : b;
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign full     = neg_reg ? -acc_next : acc_next;

    assign done    = busy_reg && (cnt_reg == CW'(1));
    assign product = full[WIDTH-1:0];
    // Representable iff the top WIDTH+1 bits are all copies of the sign.
    assign ovf     = !((&full[2*WIDTH-1:WIDTH-1]) || !(|full[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            neg_reg    <= 1'b0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= CW'(WIDTH);
            mcand_reg  <= {{WIDTH{1'b0}}, abs_a};
            mplier_reg <= abs_b;
            acc_reg    <= '0;
            neg_reg    <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_cc_unit.sv
// ALU with y86-style condition codes.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : request in_* / response out_* handshakes
//   cond_fn, cnd      : condition select and its outcome from the CC register
//   cc_zf/cc_sf/cc_of : condition-code register
// ADD/SUB/AND/XOR/illegal produce a result one cycle after acceptance.
// MUL runs on alu_mul_seq; the unit stays busy (in_ready low) until the
// product lands in the output register.
module alu_cc_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int MUL_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_cc_unit_if.slave bus,
    input  logic [3:0]   cond_fn,
    output logic         cnd,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);
    state_e           state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_result_reg;
    logic             out_ovf_reg;
    logic             out_err_reg;
    logic             zf_reg;
    logic             sf_reg;
    logic             of_reg;
    logic             mul_set_cc_reg;

    op_e              op;
    logic             accept;
    logic             is_mul;
    logic             is_illegal;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_ovf;

    assign op         = op_e'(bus.in_op);
    assign is_mul     = (op == OP_MUL) && (MUL_EN != 0);
    assign is_illegal = (op inside {OP_RSV5, OP_RSV6, OP_RSV7}) ||
                        ((op == OP_MUL) && (MUL_EN == 0));
    assign bus.in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || bus.out_ready);
    assign accept     = bus.in_valid && bus.in_ready;
    assign mul_start  = accept && is_mul;

    // Single-cycle datapath. SUB is b-a to match subq rA,rB operand order.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = bus.in_a + bus.in_b;
                alu_ovf = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = bus.in_b - bus.in_a;
                alu_ovf = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.in_b[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.in_a & bus.in_b;
            OP_XOR:  alu_res = bus.in_a ^ bus.in_b;
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (bus.in_a),
                .b       (bus.in_b),
                .done    (mul_done),
                .product (mul_product),
                .ovf     (mul_ovf)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
            assign mul_ovf     = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_ovf_reg    <= 1'b0;
            out_err_reg    <= 1'b0;
            zf_reg         <= CC_ZF_RST;
            sf_reg         <= CC_SF_RST;
            of_reg         <= CC_OF_RST;
            mul_set_cc_reg <= 1'b0;
        end else begin
            // Drop valid on handshake; a result loaded below overrides this.
            if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_reg      <= ST_MUL_BUSY;
                            mul_set_cc_reg <= bus.in_set_cc;
                        end else begin
                            out_valid_reg  <= 1'b1;
                            out_result_reg <= alu_res;
                            out_ovf_reg    <= alu_ovf;
                            out_err_reg    <= is_illegal;
                            if (bus.in_set_cc && !is_illegal) begin
                                zf_reg <= (alu_res == '0);
                                sf_reg <= alu_res[WIDTH-1];
                                of_reg <= alu_ovf;
                            end
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done) begin
                        state_reg      <= ST_IDLE;
                        out_valid_reg  <= 1'b1;
                        out_result_reg <= mul_product;
                        out_ovf_reg    <= mul_ovf;
                        out_err_reg    <= 1'b0;
                        if (mul_set_cc_reg) begin
                            zf_reg <= (mul_product == '0);
                            sf_reg <= mul_product[WIDTH-1];
                            of_reg <= mul_ovf;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = out_result_reg;
    assign bus.out_ovf    = out_ovf_reg;
    assign bus.out_err    = out_err_reg;
    assign cc_zf          = zf_reg;
    assign cc_sf          = sf_reg;
    assign cc_of          = of_reg;
    assign cnd            = cond_eval(cond_fn, zf_reg, sf_reg, of_reg);
endmodule

// File: tb/tb_alu_cc_unit.sv
// Directed testbench for alu_cc_unit with a result scoreboard.
module tb_alu_cc_unit;
    logic       clk;
    logic       rst_n;
    logic [3:0] cond_fn;
    logic       cnd;
    logic       cc_zf;
    logic       cc_sf;
    logic       cc_of;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] r;
        logic        o;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    logic ezf, esf, eof;

    alu_cc_unit_if #(.WIDTH(64)) bus ();

    alu_cc_unit #(.WIDTH(64), .MUL_EN(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cond_fn (cond_fn),
        .cnd     (cnd),
        .cc_zf   (cc_zf),
        .cc_sf   (cc_sf),
        .cc_of   (cc_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour; MUL uses a full-width signed product.
    function automatic void model(input logic [2:0] op, input logic signed [63:0] a,
                                  input logic signed [63:0] b, output logic [63:0] r,
                                  output logic o, output logic e);
        logic signed [127:0] p;
        r = '0; o = 1'b0; e = 1'b0;
        case (op)
            3'd0: begin r = a + b; o = (a[63] == b[63]) && (r[63] != a[63]); end
            3'd1: begin r = b - a; o = (a[63] != b[63]) && (r[63] != b[63]); end
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: begin
                p = a * b;
                r = p[63:0];
                o = (p !== {{64{r[63]}}, r});
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic sc, input logic expect_out);
        exp_t e;
        int n;
        model(op, a, b, e.r, e.o, e.e);
        if (expect_out) begin
            exp_q.push_back(e);
            if (sc && !e.e) begin
                ezf = (e.r == 64'd0);
                esf = e.r[63];
                eof = e.o;
            end
        end
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_set_cc = sc;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        chk("send_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 1'b0;
        $display("txn op=%0d a=%0h b=%0h set_cc=%0d", op, a, b, sc);
    endtask

    task automatic chk_cc(input string tag);
        chk(tag, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, ezf, esf, eof});
    endtask

    task automatic chk_cnd(input logic [3:0] fn, input logic exp, input string tag);
        cond_fn = fn;
        #1;
        chk(tag, {63'd0, cnd}, {63'd0, exp});
    endtask

    // Result monitor: outputs are sampled mid-cycle, before the handshake edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=%0h expected=none", bus.out_result);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_result", bus.out_result, e.r);
                chk("sb_ovf", {63'd0, bus.out_ovf}, {63'd0, e.o});
                chk("sb_err", {63'd0, bus.out_err}, {63'd0, e.e});
                $display("out result=%0h ovf=%0d err=%0d", bus.out_result, bus.out_ovf, bus.out_err);
            end
        end
    end

    initial begin
        int n;
        int hits;
        rst_n         = 1'b0;
        cond_fn       = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_set_cc = 1'b0;
        bus.out_ready = 1'b1;
        ezf = 1'b1; esf = 1'b0; eof = 1'b0;

        // Reset state
        step(); step();
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_result", bus.out_result, 64'd0);
        chk("rst_ovf_err", {62'd0, bus.out_ovf, bus.out_err}, 64'd0);
        chk_cc("rst_cc");
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // ADD 11+4 with CC
        send(3'd0, 64'd11, 64'd4, 1'b1, 1'b1);
        chk("add_latency", {63'd0, bus.out_valid}, 64'd1);
        chk_cc("add_cc");

        // ADD overflow
        send(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1);
        chk_cc("addovf_cc");
        chk_cnd(4'd2, 1'b0, "addovf_cnd_l");
        chk_cnd(4'd5, 1'b1, "addovf_cnd_ge");
        chk_cnd(4'd3, 1'b0, "pre_sub_cnd_e");
        step();

        // SUB to zero; cnd E follows only after the load edge
        cond_fn = 4'd3;
        send(3'd1, 64'd5, 64'd5, 1'b1, 1'b1);
        chk("sub_cc_z", {63'd0, cnd}, 64'd1);
        chk_cc("sub_cc");

        // Logic ops without CC update
        send(3'd3, 64'hF0, 64'h0F, 1'b0, 1'b1);
        chk_cc("xor_cc_hold");
        send(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b0, 1'b1);
        chk_cc("and_cc_hold");

        // SUB overflow: MIN - 1
        send(3'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        chk_cc("subovf_cc");
        chk_cnd(4'd1, 1'b1, "subovf_cnd_le");
        chk_cnd(4'd6, 1'b0, "subovf_cnd_g");
        chk_cnd(4'd9, 1'b0, "cnd_rsv");
        step();
        chk_cnd(4'd0, 1'b1, "cnd_always");
        chk_cnd(4'd4, 1'b1, "cnd_ne");
        step();

        // MUL -3*7: latency and busy window
        send(3'd4, -64'sd3, 64'd7, 1'b1, 1'b1);
        n = 1; hits = 0;
        while (!bus.out_valid && n < 200) begin
            if (bus.in_ready) hits++;
            step();
            n++;
        end
        chk("mul_latency", 64'(n), 64'd65);
        chk("mul_busy_ready", 64'(hits), 64'd0);
        step();
        chk_cc("mul_cc");
        chk_cnd(4'd2, 1'b1, "mul_cnd_l");

        // MUL overflow 2^62*4
        send(3'd4, 64'h4000_0000_0000_0000, 64'd4, 1'b1, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 200) begin step(); n++; end
        chk("mulovf_seen", {63'd0, bus.out_valid}, 64'd1);
        step();
        chk_cc("mulovf_cc");
        chk_cnd(4'd1, 1'b1, "mulovf_cnd_le");

        // MUL MIN*-1 boundary, no CC
        send(3'd4, 64'h8000_0000_0000_0000, -64'sd1, 1'b0, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 200) begin step(); n++; end
        chk("mulmin_seen", {63'd0, bus.out_valid}, 64'd1);
        step();
        chk_cc("mulmin_cc_hold");

        // Backpressure with a second request waiting
        bus.out_ready = 1'b0;
        send(3'd0, 64'd100, -64'sd1, 1'b0, 1'b1);
        send_pending: begin
            exp_t e2;
            model(3'd3, 64'hAA, 64'h55, e2.r, e2.o, e2.e);
            exp_q.push_back(e2);
            bus.in_valid = 1'b1; bus.in_op = 3'd3;
            bus.in_a = 64'hAA; bus.in_b = 64'h55; bus.in_set_cc = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk("stall_result", bus.out_result, 64'd99);
                chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
                chk("stall_ready", {63'd0, bus.in_ready}, 64'd0);
                step();
            end
            bus.out_ready = 1'b1;
            #1;
            chk("release_ready", {63'd0, bus.in_ready}, 64'd1);
            step();
            bus.in_valid = 1'b0;
            chk("nobubble_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("nobubble_result", bus.out_result, e2.r);
            $display("txn op=3 a=aa b=55 set_cc=0 (accepted on release)");
        end

        // Illegal op
        send(3'd7, 64'd9, 64'd9, 1'b1, 1'b1);
        chk("ill_err", {63'd0, bus.out_err}, 64'd1);
        chk_cc("ill_cc_hold");

        // Make ZF=0 before reset test
        send(3'd0, 64'd1, 64'd1, 1'b1, 1'b1);
        chk_cc("pre_rst_cc");
        step();

        // Reset in the middle of a MUL
        send(3'd4, 64'd5, 64'd6, 1'b1, 1'b0);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        ezf = 1'b1; esf = 1'b0; eof = 1'b0;
        chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk_cc("midrst_cc");
        step(); step();
        rst_n = 1'b1;
        step();
        chk("postrst_ready", {63'd0, bus.in_ready}, 64'd1);
        hits = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.out_valid) hits++;
            step();
        end
        chk("postrst_no_result", 64'(hits), 64'd0);
        chk_cc("postrst_cc");

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
